// File: rtl/csa_tree_pipe.sv
// Pipelined multi-operand carry-save adder tree: registered 3:2 levels followed
// by a registered carry-propagate stage, with a whole-pipe valid/ready stall.
module csa_tree_pipe #(
  parameter int WIDTH  = 16,
  parameter int N_OPS  = 4,
  parameter int SIGNED = 0,
  parameter int TAG_W  = 4,
  localparam int OW    = WIDTH + $clog2(N_OPS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_OPS*WIDTH-1:0] in_data,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OW-1:0]          out_sum,
  output logic [OW-1:0]          out_carry,
  output logic [OW-1:0]          out_result,
  output logic [TAG_W-1:0]       out_tag
);

  typedef logic [N_OPS-1:0][OW-1:0] rows_t;

  function automatic int rows_after(input int n);
    return 2 * (n / 3) + (n % 3);
  endfunction

  function automatic int rows_at(input int lvl);
    int n;
    n = N_OPS;
    for (int i = 0; i < lvl; i++) n = rows_after(n);
    return n;
  endfunction

  function automatic int num_levels(input int n0);
    int n;
    int c;
    n = n0;
    c = 0;
    for (int i = 0; i < 16; i++) begin
      if (n > 2) begin
        n = rows_after(n);
        c++;
      end
    end
    return c;
  endfunction

  // One 3:2 level: groups of three rows become (sum, shifted carry), leftovers pass through.
  function automatic rows_t csa_level(input rows_t r, input int n);
    rows_t o;
    int    g3;
    logic [OW-1:0] maj;
    o  = '0;
    g3 = n / 3;
    for (int g = 0; g < N_OPS / 3; g++) begin
      if (g < g3) begin
        maj        = (r[3*g] & r[3*g+1]) | (r[3*g] & r[3*g+2]) | (r[3*g+1] & r[3*g+2]);
        o[2*g]     = r[3*g] ^ r[3*g+1] ^ r[3*g+2];
        o[2*g+1]   = {maj[OW-2:0], 1'b0};
      end
    end
    for (int j = 0; j < 2; j++) begin
      if (j < n % 3) o[2*g3+j] = r[3*g3+j];
    end
    return o;
  endfunction

  localparam int L = num_levels(N_OPS);

  generate
    if (N_OPS < 3 || N_OPS > 9) begin : g_bad_nops
      $error("csa_tree_pipe: N_OPS must lie in 3..9");
    end
  endgenerate

  logic              en_s;
  rows_t             ext_s;
  rows_t             stage_d [1:L];
  rows_t             stage_q [1:L];
  logic [TAG_W-1:0]  tag_q   [1:L];
  logic [L:1]        vld_q;
  logic              out_valid_q;
  logic [OW-1:0]     out_sum_q, out_carry_q, out_result_q;
  logic [TAG_W-1:0]  out_tag_q;

  assign en_s     = out_ready | ~out_valid_q;
  assign in_ready = en_s;

  // Operand extension to OW bits followed by the combinational part of every level.
  always_comb begin
    ext_s = '0;
    for (int k = 0; k < N_OPS; k++) begin
      if (SIGNED != 0) begin
        ext_s[k] = {{(OW-WIDTH){in_data[k*WIDTH+WIDTH-1]}}, in_data[k*WIDTH +: WIDTH]};
      end else begin
        ext_s[k] = {{(OW-WIDTH){1'b0}}, in_data[k*WIDTH +: WIDTH]};
      end
    end
    stage_d[1] = csa_level(ext_s, N_OPS);
    for (int l = 2; l <= L; l++) begin
      stage_d[l] = csa_level(stage_q[l-1], rows_at(l-1));
    end
  end

  // Level data and tags: no reset needed, validity is tracked separately.
  always_ff @(posedge clk) begin
    if (en_s) begin
      stage_q  <= stage_d;
      tag_q[1] <= in_tag;
      for (int l = 2; l <= L; l++) tag_q[l] <= tag_q[l-1];
    end
  end

  // Valid chain and the output stage; the final two rows are always (sum, carry).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q        <= '0;
      out_valid_q  <= 1'b0;
      out_sum_q    <= '0;
      out_carry_q  <= '0;
      out_result_q <= '0;
      out_tag_q    <= '0;
    end else if (en_s) begin
      vld_q[1] <= in_valid;
      for (int l = 2; l <= L; l++) vld_q[l] <= vld_q[l-1];
      out_valid_q  <= vld_q[L];
      out_sum_q    <= stage_q[L][0];
      out_carry_q  <= stage_q[L][1];
      out_result_q <= stage_q[L][0] + stage_q[L][1];
      out_tag_q    <= tag_q[L];
    end
  end

  assign out_valid  = out_valid_q;
  assign out_sum    = out_sum_q;
  assign out_carry  = out_carry_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;

endmodule

// File: tb/tb_csa_tree_pipe.sv
// Self-checking bench for csa_tree_pipe: default, signed and N_OPS 9/3/5/7 instances
// driven from shared handshake signals.
module tb_csa_tree_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [63:0] in_data;
  logic [71:0] in_data8;
  logic [3:0]  in_tag;

  always #5 clk = ~clk;

  logic        a_ir, a_ov, s_ir, s_ov, n9_ir, n9_ov, n3_ir, n3_ov, n5_ir, n5_ov, n7_ir, n7_ov;
  logic [17:0] a_sum, a_car, a_res, s_sum, s_car, s_res;
  logic [11:0] n9_sum, n9_car, n9_res;
  logic [9:0]  n3_sum, n3_car, n3_res;
  logic [10:0] n5_sum, n5_car, n5_res, n7_sum, n7_car, n7_res;
  logic [3:0]  a_tag, s_tag, n9_tag, n3_tag, n5_tag, n7_tag;

  csa_tree_pipe u_a (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_ir),
    .in_data(in_data), .in_tag(in_tag), .out_valid(a_ov), .out_ready(out_ready),
    .out_sum(a_sum), .out_carry(a_car), .out_result(a_res), .out_tag(a_tag));
  csa_tree_pipe #(.SIGNED(1)) u_s (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_ir),
    .in_data(in_data), .in_tag(in_tag), .out_valid(s_ov), .out_ready(out_ready),
    .out_sum(s_sum), .out_carry(s_car), .out_result(s_res), .out_tag(s_tag));
  csa_tree_pipe #(.WIDTH(8), .N_OPS(9)) u_n9 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(n9_ir),
    .in_data(in_data8), .in_tag(in_tag), .out_valid(n9_ov), .out_ready(out_ready),
    .out_sum(n9_sum), .out_carry(n9_car), .out_result(n9_res), .out_tag(n9_tag));
  csa_tree_pipe #(.WIDTH(8), .N_OPS(3)) u_n3 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(n3_ir),
    .in_data(in_data8[23:0]), .in_tag(in_tag), .out_valid(n3_ov), .out_ready(out_ready),
    .out_sum(n3_sum), .out_carry(n3_car), .out_result(n3_res), .out_tag(n3_tag));
  csa_tree_pipe #(.WIDTH(8), .N_OPS(5)) u_n5 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(n5_ir),
    .in_data(in_data8[39:0]), .in_tag(in_tag), .out_valid(n5_ov), .out_ready(out_ready),
    .out_sum(n5_sum), .out_carry(n5_car), .out_result(n5_res), .out_tag(n5_tag));
  csa_tree_pipe #(.WIDTH(8), .N_OPS(7)) u_n7 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(n7_ir),
    .in_data(in_data8[55:0]), .in_tag(in_tag), .out_valid(n7_ov), .out_ready(out_ready),
    .out_sum(n7_sum), .out_carry(n7_car), .out_result(n7_res), .out_tag(n7_tag));

  // Per-instance views: 0=default, 1=signed, 2=N9, 3=N3, 4=N5, 5=N7.
  logic [5:0]       ov, cons;
  logic [5:0][17:0] res;
  logic [5:0][3:0]  tg;
  assign ov      = {n7_ov, n5_ov, n3_ov, n9_ov, s_ov, a_ov};
  assign res[0]  = a_res;
  assign res[1]  = s_res;
  assign res[2]  = {6'd0, n9_res};
  assign res[3]  = {8'd0, n3_res};
  assign res[4]  = {7'd0, n5_res};
  assign res[5]  = {7'd0, n7_res};
  assign tg      = {n7_tag, n5_tag, n3_tag, n9_tag, s_tag, a_tag};
  assign cons[0] = (a_sum + a_car) == a_res;
  assign cons[1] = (s_sum + s_car) == s_res;
  assign cons[2] = (n9_sum + n9_car) == n9_res;
  assign cons[3] = (n3_sum + n3_car) == n3_res;
  assign cons[4] = (n5_sum + n5_car) == n5_res;
  assign cons[5] = (n7_sum + n7_car) == n7_res;

  typedef struct {
    logic [63:0] d;
    logic [71:0] d8;
    logic [3:0]  tag;
    logic [17:0] exp_u;
    logic [17:0] exp_s;
  } vec_t;

  vec_t        tbl [6];
  int          checks = 0;
  int          errors = 0;
  int          exp_lat [6];
  int          m_lat [6];
  int          m_cnt [6];
  logic [17:0] m_res [6];
  logic [3:0]  m_tag [6];
  logic        m_cons [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, expv);
    end
  endtask

  function automatic logic [17:0] ref16(input logic [63:0] d);
    logic [17:0] s;
    s = '0;
    for (int k = 0; k < 4; k++) s = s + {2'b00, d[k*16 +: 16]};
    return s;
  endfunction

  function automatic logic [17:0] ref8(input logic [71:0] d, input int n);
    logic [17:0] s;
    s = '0;
    for (int k = 0; k < n; k++) s = s + {10'd0, d[k*8 +: 8]};
    return s;
  endfunction

  task automatic send_one(input logic [63:0] d, input logic [71:0] d8, input logic [3:0] t);
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_data8 = d8; in_tag = t;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Watches all instances for 10 cycles after the accept edge (edge count starts at 1).
  task automatic observe();
    for (int k = 0; k < 6; k++) begin
      m_lat[k] = 0; m_cnt[k] = 0; m_res[k] = '0; m_tag[k] = '0; m_cons[k] = 1'b0;
    end
    for (int c = 1; c <= 10; c++) begin
      for (int k = 0; k < 6; k++) begin
        if (ov[k]) begin
          m_cnt[k]++;
          if (m_lat[k] == 0) begin
            m_lat[k] = c; m_res[k] = res[k]; m_tag[k] = tg[k]; m_cons[k] = cons[k];
          end
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic run_stream(input int nsets, input int stall_at, input int stall_len);
    logic [17:0] exp_q [$];
    logic [3:0]  tag_q [$];
    logic [17:0] snap_r, snap_s, e_r;
    logic [3:0]  snap_t, e_t;
    logic        acc, snap_ok;
    int          sent, got, cyc, first, last;
    acc = 1'b1; snap_ok = 1'b0; sent = 0; got = 0; cyc = 0; first = -1; last = -1;
    while (got < nsets && cyc < 200) begin
      @(negedge clk);
      if (acc) begin
        if (sent < nsets) begin
          in_data = {$urandom(), $urandom()}; in_tag = sent[3:0]; in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      #1;
      if (a_ov && !out_ready) begin
        chk("stall_in_ready", {31'd0, a_ir}, 32'd0);
        if (snap_ok) begin
          chk("stall_result_frozen", {14'd0, a_res}, {14'd0, snap_r});
          chk("stall_sum_frozen", {14'd0, a_sum}, {14'd0, snap_s});
          chk("stall_tag_frozen", {28'd0, a_tag}, {28'd0, snap_t});
        end else begin
          snap_r = a_res; snap_s = a_sum; snap_t = a_tag; snap_ok = 1'b1;
        end
      end else begin
        snap_ok = 1'b0;
      end
      if (a_ov && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("stream_unexpected_output", 32'd1, 32'd0);
        end else begin
          e_r = exp_q.pop_front(); e_t = tag_q.pop_front();
          chk("stream_result", {14'd0, a_res}, {14'd0, e_r});
          chk("stream_tag", {28'd0, a_tag}, {28'd0, e_t});
          chk("stream_consistent", {31'd0, cons[0]}, 32'd1);
        end
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      acc = in_valid && a_ir;
      if (acc) begin
        exp_q.push_back(ref16(in_data)); tag_q.push_back(in_tag); sent++;
      end
      cyc++;
    end
    chk("stream_count", got, nsets);
    if (stall_len == 0) chk("stream_one_per_cycle", last - first, nsets - 1);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [95:0]       rnd;
    logic [5:0][17:0]  e;
    int                vcnt;
    exp_lat = '{3, 3, 5, 2, 4, 5};
    tbl[0] = '{64'hFFFF_FFFF_FFFF_FFFF, {9{8'hFF}}, 4'h5, 18'h3FFFC, 18'h3FFFC};
    tbl[1] = '{64'h0003_0002_0001_FFFF, 72'd0, 4'hA, 18'h10005, 18'h00005};
    tbl[2] = '{64'h8000_8000_8000_8000, 72'd0, 4'h3, 18'h20000, 18'h20000};
    tbl[3] = '{64'h7FFF_7FFF_7FFF_7FFF, 72'd0, 4'hC, 18'h1FFFC, 18'h1FFFC};
    tbl[4] = '{64'h0000_0000_0000_0000, 72'd0, 4'h6, 18'h00000, 18'h00000};
    tbl[5] = '{64'h7FFF_8000_0001_1234, 72'd0, 4'h9, 18'h11234, 18'h01234};
    for (int i = 1; i < 6; i++) begin
      rnd = {$urandom(), $urandom(), $urandom()};
      tbl[i].d8 = rnd[71:0];
    end

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_data = '0; in_data8 = '0; in_tag = '0;
    #3;
    chk("reset_out_valid", {31'd0, a_ov}, 32'd0);
    chk("reset_out_result", {14'd0, a_res}, 32'd0);
    chk("reset_out_sum", {14'd0, a_sum}, 32'd0);
    chk("reset_out_carry", {14'd0, a_car}, 32'd0);
    chk("reset_out_tag", {28'd0, a_tag}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_reset", {31'd0, a_ir}, 32'd1);

    for (int i = 0; i < 6; i++) begin
      send_one(tbl[i].d, tbl[i].d8, tbl[i].tag);
      observe();
      e[0] = tbl[i].exp_u; e[1] = tbl[i].exp_s;
      e[2] = ref8(tbl[i].d8, 9); e[3] = ref8(tbl[i].d8, 3);
      e[4] = ref8(tbl[i].d8, 5); e[5] = ref8(tbl[i].d8, 7);
      for (int k = 0; k < 6; k++) begin
        chk($sformatf("latency_dut%0d_row%0d", k, i), m_lat[k], exp_lat[k]);
        chk($sformatf("valid_cycles_dut%0d_row%0d", k, i), m_cnt[k], 1);
        chk($sformatf("result_dut%0d_row%0d", k, i), {14'd0, m_res[k]}, {14'd0, e[k]});
        chk($sformatf("tag_dut%0d_row%0d", k, i), {28'd0, m_tag[k]}, {28'd0, tbl[i].tag});
        chk($sformatf("sum_carry_dut%0d_row%0d", k, i), {31'd0, m_cons[k]}, 32'd1);
      end
      if (i == 0) chk("n9_all_ff", {14'd0, m_res[2]}, 32'h8F7);
    end

    run_stream(20, 1000, 0);
    run_stream(12, 6, 5);

    // Reset with three sets in flight.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = tbl[i].d; in_tag = tbl[i].tag;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("midrst_pipe_loaded", {31'd0, a_ov}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, a_ov}, 32'd0);
    chk("midrst_out_result", {14'd0, a_res}, 32'd0);
    chk("midrst_out_sum", {14'd0, a_sum}, 32'd0);
    chk("midrst_out_carry", {14'd0, a_car}, 32'd0);
    chk("midrst_out_tag", {28'd0, a_tag}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    vcnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (a_ov) vcnt++;
    end
    chk("midrst_no_stale_output", vcnt, 0);
    send_one(tbl[1].d, tbl[1].d8, tbl[1].tag);
    observe();
    chk("postrst_latency", m_lat[0], 3);
    chk("postrst_result_unsigned", {14'd0, m_res[0]}, 32'h10005);
    chk("postrst_result_signed", {14'd0, m_res[1]}, 32'h00005);
    chk("postrst_tag", {28'd0, m_tag[0]}, 32'hA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/csa_tree_pipe.md
Name: csa_tree_pipe

Overview:
- Parametrised, pipelined multi-operand carry-save adder tree.
- Reduces N_OPS operands of WIDTH bits through registered levels of 3:2 compressors, then a final registered carry-propagate add.
- Serves the DSP datapath as the generalised successor of the fixed-width combinational 3:2/4:2 compressors.
- Adds a valid/ready handshake, a tag sideband, a signed mode and full-pipeline stall.

Parameters:
- WIDTH, 16, bits per operand.
- N_OPS, 4, number of operands (legal range 3..9; anything else is an elaboration error).
- SIGNED, 0, 1 = operands are two's complement and sign-extended; 0 = zero-extended.
- TAG_W, 4, width of the sideband tag carried alongside each operand set.
- OW, WIDTH+$clog2(N_OPS), derived output width (not overridable).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand set present.
- in_ready  out  1  block accepts the operand set this cycle.
- in_data  in  N_OPS*WIDTH  operand k occupies bits [k*WIDTH +: WIDTH].
- in_tag  in  TAG_W  sideband, returned unchanged with the result.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  OW  final CSA sum vector (registered with the result).
- out_carry  out  OW  final CSA carry vector, already shifted into its bit position.
- out_result  out  OW  out_sum + out_carry mod 2^OW = exact sum of the operands.
- out_tag  out  TAG_W  tag of the operand set.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: all stage valid bits, out_valid, out_sum, out_carry, out_result and out_tag are 0. Data registers may be left unreset internally, but the outputs must read 0.
- After reset is released, in_ready = 1.
- Extension: each operand is extended to OW bits (sign-extended if SIGNED=1, zero-extended otherwise) before level 1.
- CSA levels: each level greedily groups its rows in threes. A group of three becomes a sum and carry pair; leftover rows pass through. Rows per level: ceil(2n/3) until 2 rows remain.
- Level counts L: N_OPS 3 → 1; 4 → 2; 5..6 → 3; 7..9 → 4.
- Registering: each level is registered. A final stage registers out_sum, out_carry and out_result.
- Latency: L+1 cycles from the accept edge to out_valid. Example: N_OPS=4 gives 3 cycles.
- All internal arithmetic is OW bits wide, and carries shifted above bit OW-1 are dropped. OW guarantees no loss for unsigned inputs and correct two's-complement results for signed inputs.
- Handshake: one global enable, en = out_ready | ~out_valid, and in_ready = en.
  - A transfer occurs when in_valid & in_ready.
  - When en = 1, every stage (data, tag, valid) advances one position and stage 1 valid takes in_valid.
  - When en = 0, all stages hold.
  - Bubbles are not squeezed out; the pipeline stalls as a whole.
- Throughput: one operand set per cycle while out_ready is held at 1.
- Output stability: out_* is stable while out_valid=1 and out_ready=0.
- Output drop: out_valid falls on the cycle after a transfer if no valid data arrives behind it.
- in_valid when in_ready=0: ignored, nothing is captured; the source must hold its data.
- Simultaneous output accept and input accept in the same cycle is legal and loses no data.
- Reset asserted mid-operation: all in-flight sets are discarded immediately (asynchronously). No partial result is emitted after rst_n is released.
- Invariant on every out_valid cycle: out_result == (out_sum + out_carry) mod 2^OW.

Test Plan:
- Unsigned, defaults: 4 × 0xFFFF with tag 0x5 → after 3 cycles out_result=0x3FFFC, out_tag=0x5, sum+carry consistent.
- Sign mode, same input: 0xFFFF,0x0001,0x0002,0x0003.
  - SIGNED=0 → out_result=0x10005.
  - SIGNED=1 → out_result=0x00005.
  - SIGNED=1 with 4 × 0x8000 → 0x20000 (-131072).
- Streaming: 20 back-to-back random sets with out_ready=1 → 20 results, in order, one per cycle, tags matching, all equal to the reference sum.
- Backpressure: deassert out_ready for 5 cycles while in_valid stays high.
  - in_ready=0 and all outputs are frozen during the stall.
  - After release, no set is lost or duplicated (scoreboard by tag).
- Reset mid-flight: assert rst_n=0 with 3 sets in the pipe → outputs immediately 0 and out_valid=0; no stale output after release; the next set produces a correct result.
- Parameter sweep: N_OPS=9, WIDTH=8, 9 × 0xFF → OW=12, latency 5, out_result=0x8F7. Repeat for N_OPS=3, 5 and 7 with random data.
